// File: rtl/iterative_mac_seq.sv
// Iterative signed multiply-accumulate: bias + sum(a[i]*w[i]) using a radix-2^DIGIT
// shift-add multiplier and a saturating accumulator, with ready/valid on both sides.
module iterative_mac_seq #(
  parameter int A_W   = 8,
  parameter int W_W   = 8,
  parameter int DIGIT = 2,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [ACC_W-1:0] i_bias,
  input  logic             i_relu,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [A_W-1:0]   i_a,
  input  logic [W_W-1:0]   i_w,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_sat,
  output logic             o_busy
);

  localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int MUL_CYC  = W_W / DIG_SAFE;
  localparam int P_W      = A_W + W_W;
  localparam int MC_W     = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [MC_W-1:0]  MC_LAST = MC_W'(MUL_CYC - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  generate
    if ((DIGIT < 1) || (A_W < 2) || (W_W < 1) || (LEN_W < 1) || (DIGIT > W_W) ||
        ((W_W % DIG_SAFE) != 0) || (ACC_W < A_W + W_W + 1)) begin : g_param_check
      $error("iterative_mac_seq: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_relu;
  logic               r_sat;
  logic signed [P_W-1:0] r_a_sh;
  logic [W_W-1:0]     r_w;
  logic signed [P_W-1:0] r_prod;
  logic [MC_W-1:0]    r_mc;

  logic [DIGIT-1:0]      w_digit;
  logic [DIGIT:0]        w_digit_s;
  logic signed [P_W-1:0] w_digit_ext;
  logic signed [P_W-1:0] w_mult;
  logic [ACC_W:0]        w_sum;
  logic                  w_ovf;
  logic [ACC_W-1:0]      w_acc_add;

  function automatic logic [ACC_W-1:0] relu_fn(input logic [ACC_W-1:0] v, input logic en);
    logic [ACC_W-1:0] r;
    if (en && v[ACC_W-1]) begin
      r = '0;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_len == '0) ? S_DONE : S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (i_in_valid) begin
          w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_MUL: begin
        if (r_mc == MC_LAST) begin
          w_state_nxt = S_ACC;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_ACC: begin
        if (r_cnt == LEN_W'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Digit multiple (top digit signed) and saturating accumulate
  always_comb begin
    w_digit = r_w[DIGIT-1:0];
    if (r_mc == MC_LAST) begin
      w_digit_s = {w_digit[DIGIT-1], w_digit};
    end else begin
      w_digit_s = {1'b0, w_digit};
    end
    w_digit_ext = {{(P_W-DIGIT-1){w_digit_s[DIGIT]}}, w_digit_s};
    w_mult      = r_a_sh * w_digit_ext;
    w_sum       = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-P_W){r_prod[P_W-1]}}, r_prod};
    w_ovf       = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (w_ovf) begin
      w_acc_add = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_acc_add = w_sum[ACC_W-1:0];
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_relu      <= 1'b0;
      r_sat       <= 1'b0;
      r_a_sh      <= '0;
      r_w         <= '0;
      r_prod      <= '0;
      r_mc        <= '0;
      o_in_ready  <= 1'b0;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_acc       <= '0;
      o_sat       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      o_in_ready  <= (w_state_nxt == S_LOAD);
      o_out_valid <= (w_state_nxt == S_DONE);
      o_busy      <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc  <= i_bias;
            r_cnt  <= i_len;
            r_relu <= i_relu;
            r_sat  <= 1'b0;
            if (i_len == '0) begin
              o_acc <= relu_fn(i_bias, i_relu);
              o_sat <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (i_in_valid) begin
            r_a_sh <= {{W_W{i_a[A_W-1]}}, i_a};
            r_w    <= i_w;
            r_prod <= '0;
            r_mc   <= '0;
          end
        end
        S_MUL: begin
          r_prod <= r_prod + w_mult;
          r_a_sh <= r_a_sh <<< DIGIT;
          r_w    <= r_w >> DIGIT;
          r_mc   <= r_mc + MC_W'(1);
        end
        S_ACC: begin
          r_acc <= w_acc_add;
          r_sat <= r_sat | w_ovf;
          r_cnt <= r_cnt - LEN_W'(1);
          // Results are published only on the final accumulate so they hold elsewhere
          if (r_cnt == LEN_W'(1)) begin
            o_acc <= relu_fn(w_acc_add, r_relu);
            o_sat <= r_sat | w_ovf;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_mac_seq.sv
// Bench for iterative_mac_seq: directed vectors on a 17-bit-accumulator instance plus
// randomized vectors on a sweep of DIGIT/width configurations, all checked against a model.
module tb_iterative_mac_seq;

  localparam int M_AW  = 8;
  localparam int M_WW  = 8;
  localparam int M_ACC = 17;
  localparam int NCFG  = 7;
  localparam int NVEC  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer accumulate with clamping to the ACC_W signed range.
  function automatic longint sat_add(input longint acc, input longint p, input int accw, inout bit s);
    longint mx, mn, r;
    mx = (longint'(1) <<< (accw - 1)) - 1;
    mn = -mx - 1;
    r  = acc + p;
    if (r > mx) begin r = mx; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
    return r;
  endfunction

  // ---------------- main (directed) instance ----------------
  logic             m_start = 1'b0, m_relu = 1'b0, m_in_valid = 1'b0, m_out_ready = 1'b0;
  logic [7:0]       m_len = '0;
  logic [M_ACC-1:0] m_bias = '0;
  logic [M_AW-1:0]  m_a = '0;
  logic [M_WW-1:0]  m_w = '0;
  logic             m_in_ready, m_out_valid, m_sat, m_busy;
  logic [M_ACC-1:0] m_acc;

  iterative_mac_seq #(.A_W(M_AW), .W_W(M_WW), .DIGIT(2), .ACC_W(M_ACC), .LEN_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(m_start), .i_len(m_len), .i_bias(m_bias),
    .i_relu(m_relu), .i_in_valid(m_in_valid), .o_in_ready(m_in_ready), .i_a(m_a), .i_w(m_w),
    .o_out_valid(m_out_valid), .i_out_ready(m_out_ready), .o_acc(m_acc), .o_sat(m_sat),
    .o_busy(m_busy)
  );

  longint m_exp_acc = 0;
  bit     m_exp_sat = 1'b0, m_exp_on = 1'b0, m_prev_valid = 1'b0, m_prev_ready = 1'b0;
  int     m_start_cyc = 0, m_valid_cyc = 0, m_lat = 0;
  longint m_res = 0;
  int     rdy_q[$];
  int     pa[4], pw[4];

  // Compare process for the main instance
  always @(negedge clk) begin
    if (m_out_valid) begin
      chk("main out_valid allowed", m_out_valid, m_exp_on);
      if (m_exp_on) begin
        chk("main acc_o", longint'($signed(m_acc)), m_exp_acc);
        chk("main sat_o", m_sat, m_exp_sat);
      end
      if (!m_prev_valid) m_valid_cyc = cyc;
    end
    m_prev_valid = m_out_valid;
    if (m_in_ready && !m_prev_ready) rdy_q.push_back(cyc);
    m_prev_ready = m_in_ready;
  end

  task automatic main_accept(input int av, input int wv);
    bit r, ok;
    int n;
    m_in_valid = 1'b1;
    m_a = M_AW'(av);
    m_w = M_WW'(wv);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge clk); r = m_in_ready;
      @(posedge clk); #1; ok = r; n++;
    end
    if (!ok) chk("main in_ready timeout", m_in_ready, 1);
  endtask

  task automatic run_main(input int len, input longint bias, input bit relu, input int hold, input bit poke);
    bit s;
    longint acc;
    int n;
    s = 1'b0;
    acc = bias;
    for (int i = 0; i < len; i++) acc = sat_add(acc, longint'(pa[i]) * longint'(pw[i]), M_ACC, s);
    m_exp_acc = (relu && acc < 0) ? 0 : acc;
    m_exp_sat = s;
    m_exp_on  = 1'b1;
    m_res     = m_exp_acc;
    rdy_q.delete();
    m_start = 1'b1; m_len = 8'(len); m_bias = M_ACC'(bias); m_relu = relu;
    @(posedge clk); #1;
    m_start = 1'b0;
    m_start_cyc = cyc;
    for (int i = 0; i < len; i++) main_accept(pa[i], pw[i]);
    m_in_valid = 1'b0;
    n = 0;
    while (!m_out_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (!m_out_valid) chk("main out_valid timeout", m_out_valid, 1);
    if (poke) begin m_start = 1'b1; m_len = 8'd1; m_bias = M_ACC'(5); end
    for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    m_start = 1'b0;
    m_exp_on = 1'b0;
    m_lat = m_valid_cyc - m_start_cyc;
  endtask

  // ---------------- randomized parameter sweep ----------------
  wire [NCFG-1:0] sw_done;

  for (genvar g = 0; g < NCFG; g++) begin : g_sw
    localparam int AW = (g < 4) ? 8 : 4;
    localparam int WW = (g < 4) ? 8 : 12;
    localparam int DG = (g < 4) ? (1 << g) : (1 << (g - 4));
    logic          start = 1'b0, relu = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]    len = '0;
    logic [31:0]   bias = '0;
    logic [AW-1:0] a = '0;
    logic [WW-1:0] w = '0;
    logic          in_ready, out_valid, sat, busy;
    logic [31:0]   acc;
    longint        exp_acc = 0;
    bit            exp_sat = 1'b0, exp_on = 1'b0, done = 1'b0;
    assign sw_done[g] = done;

    iterative_mac_seq #(.A_W(AW), .W_W(WW), .DIGIT(DG)) u_sw (
      .i_clk(clk), .i_rst(sw_rst), .i_start(start), .i_len(len), .i_bias(bias),
      .i_relu(relu), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_a(a), .i_w(w),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_acc(acc), .o_sat(sat),
      .o_busy(busy)
    );

    always @(negedge clk) begin
      if (out_valid) begin
        chk($sformatf("sweep%0d out_valid allowed", g), out_valid, exp_on);
        if (exp_on) begin
          chk($sformatf("sweep%0d acc_o", g), longint'($signed(acc)), exp_acc);
          chk($sformatf("sweep%0d sat_o", g), sat, exp_sat);
        end
      end
    end

    initial begin
      logic [AW-1:0] ta[4];
      logic [WW-1:0] tw[4];
      longint ac;
      bit s, r, ok;
      int ln, n;
      #1;
      wait (sw_rst == 1'b0);
      @(posedge clk); #1;
      for (int v = 0; v < NVEC; v++) begin
        ln = $urandom_range(0, 4);
        bias = $urandom;
        if (v % 4 == 1) bias = 32'h7FFF_FF00;
        if (v % 4 == 2) bias = 32'h8000_0100;
        relu = 1'($urandom_range(0, 1));
        ac = longint'($signed(bias));
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
          ta[i] = AW'($urandom);
          tw[i] = WW'($urandom);
          if (i < ln) ac = sat_add(ac, longint'($signed(ta[i])) * longint'($signed(tw[i])), 32, s);
        end
        exp_acc = (relu && ac < 0) ? 0 : ac;
        exp_sat = s;
        exp_on  = 1'b1;
        start = 1'b1; len = 8'(ln);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < ln; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          in_valid = 1'b1; a = ta[i]; w = tw[i];
          ok = 1'b0; n = 0;
          while (!ok && n < 100) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1; ok = r; n++;
          end
          if (!ok) chk($sformatf("sweep%0d in_ready timeout", g), in_ready, 1);
          in_valid = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        if (!out_valid) chk($sformatf("sweep%0d out_valid timeout", g), out_valid, 1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_on = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 sw_rst = 1'b0;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", m_in_ready, 0);
    chk("reset out_valid", m_out_valid, 0);
    chk("reset busy", m_busy, 0);
    chk("reset acc_o", m_acc, 0);
    chk("reset sat_o", m_sat, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    pa = '{3, 0, 0, 0}; pw = '{4, 0, 0, 0};
    run_main(1, 10, 1'b0, 0, 1'b0);
    chk("basic model value", m_res, 22);
    chk("basic latency", m_lat, 6);

    pa = '{-128, -5, 127, 0}; pw = '{-128, 7, -128, 0};
    run_main(3, 0, 1'b0, 0, 1'b0);
    chk("signed model value", m_res, 93);
    chk("signed latency", m_lat, 18);
    chk("in_ready rises", rdy_q.size(), 3);
    if (rdy_q.size() == 3) begin
      chk("in_ready first rise", rdy_q[0] - m_start_cyc, 0);
      chk("in_ready period 1", rdy_q[1] - rdy_q[0], 6);
      chk("in_ready period 2", rdy_q[2] - rdy_q[1], 6);
    end

    pa = '{-5, 0, 0, 0}; pw = '{7, 0, 0, 0};
    run_main(1, 0, 1'b0, 1, 1'b0);
    chk("relu off model", m_res, -35);
    run_main(1, 0, 1'b1, 1, 1'b0);
    chk("relu on model", m_res, 0);

    pa = '{1, -1, 0, 0}; pw = '{1, 1, 0, 0};
    run_main(2, 65535, 1'b0, 0, 1'b0);
    chk("sat pos model", m_res, 65534);
    chk("sat pos flag model", m_exp_sat, 1);
    pa = '{-1, 0, 0, 0}; pw = '{1, 0, 0, 0};
    run_main(1, -65536, 1'b0, 0, 1'b0);
    chk("sat neg model", m_res, -65536);

    // len=0 goes straight to DONE on the start edge; start held through DONE must be ignored
    run_main(0, -7, 1'b0, 5, 1'b1);
    chk("len0 model", m_res, -7);
    chk("len0 latency", m_lat, 0);
    @(negedge clk);
    chk("start ignored in DONE", m_busy, 0);
    @(posedge clk); #1;

    // Reset during the MUL phase of the second product of a len=4 vector
    m_exp_on = 1'b0;
    m_start = 1'b1; m_len = 8'd4; m_bias = M_ACC'(50); m_relu = 1'b0;
    @(posedge clk); #1;
    m_start = 1'b0;
    main_accept(9, 9);
    main_accept(9, 9);
    m_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset busy", m_busy, 1);
    chk("pre-reset in_ready", m_in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset in_ready", m_in_ready, 0);
    chk("mid reset out_valid", m_out_valid, 0);
    chk("mid reset busy", m_busy, 0);
    chk("mid reset acc_o", m_acc, 0);
    chk("mid reset sat_o", m_sat, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("post reset idle", m_busy, 0);

    pa = '{7, -3, 0, 0}; pw = '{-9, -11, 0, 0};
    run_main(2, 100, 1'b0, 2, 1'b0);
    chk("post reset model", m_res, 70);
    chk("post reset latency", m_lat, 12);

    n = 0;
    while (sw_done != {NCFG{1'b1}} && n < 20000) begin @(posedge clk); n++; end
    chk("sweep completion", sw_done, {NCFG{1'b1}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
